// File: rtl/booth_seq_mul.sv
// Sequential Booth multiplier: signed/unsigned WIDTH x WIDTH -> 2*WIDTH product under start/busy/done.
// Radix-2 by default; define BOOTH_RADIX4_EN for radix-4 (modified Booth) recoding with fewer iterations.
module booth_seq_mul #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

`ifdef BOOTH_RADIX4_EN
   localparam int N  = (WIDTH + 2) / 2;
   localparam int QW = WIDTH + 2;
`else
   localparam int N  = WIDTH + 1;
   localparam int QW = WIDTH + 1;
`endif
   localparam int CW = $clog2(N) + 1;
   localparam int AW = WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   m, a, a_nxt;
   logic [QW-1:0]   q, q_nxt;
   logic            q_m1, q_m1_nxt;
   logic [AW:0]     addend, sum;
   logic [WIDTH:0]  x_ext, y_ext;
   logic            accept, last;

   // Operands are extended by one bit so unsigned values are non-negative in the signed datapath.
   assign x_ext  = {is_signed & x[WIDTH-1], x};
   assign y_ext  = {is_signed & y[WIDTH-1], y};
   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One Booth step; the sum is one bit wider than A so that A +/- 2M cannot overflow.
   always_comb begin
      addend = '0;
`ifdef BOOTH_RADIX4_EN
      case ({q[1], q[0], q_m1})
         3'b001, 3'b010: addend = {m[AW-1], m};
         3'b011:         addend = {m, 1'b0};
         3'b100:         addend = -{m, 1'b0};
         3'b101, 3'b110: addend = -{m[AW-1], m};
         default:        addend = '0;
      endcase
      sum      = {a[AW-1], a} + addend;
      a_nxt    = {sum[AW], sum[AW:2]};
      q_nxt    = {sum[1:0], q[QW-1:2]};
      q_m1_nxt = q[1];
`else
      case ({q[0], q_m1})
         2'b01:   addend = {m[AW-1], m};
         2'b10:   addend = -{m[AW-1], m};
         default: addend = '0;
      endcase
      sum      = {a[AW-1], a} + addend;
      a_nxt    = sum[AW:1];
      q_nxt    = {sum[0], q[QW-1:1]};
      q_m1_nxt = q[0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m    <= '0;
         a    <= '0;
         q    <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
         z    <= '0;
      end else if (accept) begin
         m    <= {y_ext[WIDTH], y_ext};
`ifdef BOOTH_RADIX4_EN
         q    <= {x_ext[WIDTH], x_ext};
`else
         q    <= x_ext;
`endif
         a    <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a    <= a_nxt;
         q    <= q_nxt;
         q_m1 <= q_m1_nxt;
         cnt  <= cnt + CW'(1);
         if (last) z <= {a_nxt[2*WIDTH-QW-1:0], q_nxt};
      end
   end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: cycle-level transaction model plus directed vectors with literal products.
// Build with BOOTH_RADIX4_EN defined to check the radix-4 latency.
module tb_booth_seq_mul;
   localparam int W = 16;
`ifdef BOOTH_RADIX4_EN
   localparam int N = (W + 2) / 2;
`else
   localparam int N = W + 1;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           is_signed = 1'b0;
   logic [W-1:0]   x = '0;
   logic [W-1:0]   y = '0;
   logic           busy, done;
   logic [2*W-1:0] z;

   int n_vec = 0;
   int n_err = 0;

   booth_seq_mul #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .x(x), .y(y), .busy(busy), .done(done), .z(z)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      logic signed [2*W-1:0] sa, sb;
      if (s) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return sa * sb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   // Transaction model: an accepted product is due N edges later; nothing is accepted while one is in flight.
   logic [2*W-1:0] exp_q[$];
   bit             m_busy = 1'b0;
   bit             m_done = 1'b0;
   bit             was_busy;
   logic [2*W-1:0] m_z = '0;
   int             m_due = 0;
   int             cyc = 0;
   bit             chk_en = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_z    = '0;
         exp_q.delete();
      end else begin
         was_busy = m_busy;
         m_done   = 1'b0;
         if (was_busy && cyc == m_due) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_z    = exp_q.pop_front();
         end
         if (!was_busy && start) begin
            m_busy = 1'b1;
            m_due  = cyc + N;
            exp_q.push_back(ref_mul(x, y, is_signed));
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         if (busy !== m_busy || done !== m_done || z !== m_z) begin
            n_err++;
            $display("FAIL model cycle %0d: busy=%b done=%b z=%h, expected busy=%b done=%b z=%h",
                     cyc, busy, done, z, m_busy, m_done, m_z);
         end
      end
   end

   task automatic check_lit(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic s);
      @(posedge clk);
      #1;
      x = xv; y = yv; is_signed = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts negedges until done (k = -1 if it never comes) and how many of them showed busy.
   task automatic wait_done(output int k, output int nbusy);
      k = -1;
      nbusy = 0;
      for (int i = 1; i <= 4 * N; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            k = i;
            return;
         end
         if (busy === 1'b1) nbusy++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic s, input logic [2*W-1:0] exp);
      int k, nb;
      issue(xv, yv, s);
      wait_done(k, nb);
      check_int({name, " latency"}, k, N + 1);
      check_int({name, " busy cycles"}, nb, N);
      check_lit(name, z, exp);
   endtask

   task automatic report();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete");
      report();
      $finish;
   end

   initial begin
      int k, nb, pulses;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      check_lit("reset busy", {{(2*W-1){1'b0}}, busy}, '0);
      check_lit("reset done", {{(2*W-1){1'b0}}, done}, '0);
      check_lit("reset z", z, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op("s 3*-5",          16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1);
      run_op("s minneg^2",      16'h8000, 16'h8000, 1'b1, 32'h40000000);
      run_op("s minneg*1",      16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
      run_op("u ffff^2",        16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      run_op("s ffff^2",        16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
      run_op("s 0*x",           16'h0000, 16'h1234, 1'b1, 32'h00000000);
      run_op("s maxpos^2",      16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001);
      run_op("s minneg*maxpos", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
      run_op("u 1234*5678",     16'h1234, 16'h5678, 1'b0, 32'h06260060);
      run_op("s -1*2",          16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
      run_op("u 8000^2",        16'h8000, 16'h8000, 1'b0, 32'h40000000);
      run_op("u ff*100",        16'h00FF, 16'h0100, 1'b0, 32'h0000FF00);
      run_op("s -2*-3",         16'hFFFE, 16'hFFFD, 1'b1, 32'h00000006);

      // A start during RUN with new operands must not disturb the product in flight.
      issue(16'h0007, 16'h0009, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      x = 16'h0064; y = 16'hFF9C; is_signed = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k, nb);
      check_int("restart ignored done seen", (k > 0) ? 1 : 0, 1);
      check_lit("restart ignored z", z, 32'h0000003F);

      // Start held in the DONE cycle: the next product follows N+1 cycles after the first done.
      issue(16'h0010, 16'h0010, 1'b0);
      wait_done(k, nb);
      check_lit("b2b first z", z, 32'h00000100);
      x = 16'hFFF0; y = 16'h0003; is_signed = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k, nb);
      check_int("b2b done spacing", k, N + 1);
      check_lit("b2b second z", z, 32'hFFFFFFD0);

      // Reset in the middle of an operation aborts it; no done may follow.
      issue(16'h0123, 16'h0456, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_lit("abort busy", {{(2*W-1){1'b0}}, busy}, '0);
      check_lit("abort done", {{(2*W-1){1'b0}}, done}, '0);
      check_lit("abort z", z, '0);
      pulses = 0;
      repeat (2 * N) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check_int("abort no done", pulses, 0);
      run_op("after abort", 16'h0123, 16'h0456, 1'b0, 32'h0004EDC2);

      repeat (3) @(posedge clk);
      report();
      $finish;
   end

endmodule
